// File: rtl/floating_point_adder_normalizer.sv
// Normalising back end of the binary32 adder: takes the mantissa-ALU sum and
// the aligned exponent, shifts left one bit per cycle until the hidden bit is
// set or the exponent bottoms out, then packs the result word. Truncates only.
module floating_point_adder_normalizer #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             carry_in,
    input  logic [MAN_W-1:0] magnitude_in,
    input  logic             sign_in,
    input  logic [EXP_W-1:0] exponent_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      result,
    output logic             overflow,
    output logic             underflow
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state_q, state_n;
    logic [23:0] mant_q, mant_n;
    logic [9:0]  exp_q, exp_n;   // wide enough to hold 255 + carry without wrap
    logic        sign_q, sign_n;
    logic [31:0] result_n;
    logic        overflow_n, underflow_n;

    logic [9:0]  e_eff, e_inc, e_s;
    logic [23:0] mant_s;
    logic [32:0] packed_w;

    // Build {underflow, word}: exponent field is zero when the hidden bit never
    // surfaced, which makes any leftover fraction a subnormal.
    function automatic logic [32:0] pack(input logic s, input logic [23:0] m,
                                         input logic [9:0] e);
        logic [7:0]  field;
        logic [22:0] frac;
        field = m[23] ? e[7:0] : 8'd0;
        frac  = m[22:0];
        return {(field == 8'd0) && (frac != 23'd0), s, field, frac};
    endfunction

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);

    // Next-state, datapath and packing decisions for each FSM state.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path leaves
        // a variable unassigned, which would otherwise infer a latch.
        state_n     = state_q;
        mant_n      = mant_q;
        exp_n       = exp_q;
        sign_n      = sign_q;
        result_n    = result;
        overflow_n  = overflow;
        underflow_n = underflow;
        e_eff       = (exponent_in == 8'd0) ? 10'd1 : {2'b00, exponent_in};
        e_inc       = e_eff + 10'd1;
        mant_s      = {mant_q[22:0], 1'b0};
        e_s         = exp_q - 10'd1;
        packed_w    = '0;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_n      = sign_in;
                    overflow_n  = 1'b0;
                    underflow_n = 1'b0;
                    state_n     = DONE;
                    if (carry_in) begin
                        if (e_inc >= 10'd255) begin
                            result_n   = {sign_in, 8'hFF, 23'd0};
                            overflow_n = 1'b1;
                        end else begin
                            mant_n      = {1'b1, magnitude_in[23:1]};
                            exp_n       = e_inc;
                            packed_w    = pack(sign_in, {1'b1, magnitude_in[23:1]}, e_inc);
                            result_n    = packed_w[31:0];
                            underflow_n = packed_w[32];
                        end
                    end else if (magnitude_in == 24'd0) begin
                        result_n = 32'h0000_0000;
                    end else if (exponent_in == 8'hFF) begin
                        result_n = {sign_in, 8'hFF, 23'd0};
                    end else begin
                        mant_n = magnitude_in;
                        exp_n  = e_eff;
                        if (magnitude_in[23] || e_eff == 10'd1) begin
                            packed_w    = pack(sign_in, magnitude_in, e_eff);
                            result_n    = packed_w[31:0];
                            underflow_n = packed_w[32];
                        end else begin
                            state_n = SHIFT;
                        end
                    end
                end
            end
            SHIFT: begin
                mant_n = mant_s;
                exp_n  = e_s;
                if (mant_s[23] || e_s == 10'd1) begin
                    packed_w    = pack(sign_q, mant_s, e_s);
                    result_n    = packed_w[31:0];
                    underflow_n = packed_w[32];
                    state_n     = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State and datapath registers; synchronous reset aborts any operation.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values computed by the combinational block.
        if (reset) begin
            state_q   <= IDLE;
            mant_q    <= '0;
            exp_q     <= '0;
            sign_q    <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            state_q   <= state_n;
            mant_q    <= mant_n;
            exp_q     <= exp_n;
            sign_q    <= sign_n;
            result    <= result_n;
            overflow  <= overflow_n;
            underflow <= underflow_n;
        end
    end

endmodule

// File: tb/tb_floating_point_adder_normalizer.sv
// Scoreboard bench: driver pushes model predictions at acceptance, monitor
// compares them whenever the normaliser presents a result.
module tb_floating_point_adder_normalizer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        carry_in;
    logic [23:0] magnitude_in;
    logic        sign_in;
    logic [7:0]  exponent_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;

    typedef struct {
        logic [31:0] word;
        logic        ovf;
        logic        unf;
        int          lat;
        int          accept_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   hold     = 1'b0;
    bit   first    = 1'b1;

    floating_point_adder_normalizer dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .carry_in     (carry_in),
        .magnitude_in (magnitude_in),
        .sign_in      (sign_in),
        .exponent_in  (exponent_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    // Free-running cycle count used to measure latency.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: value-level normalisation. The number of shifts is the leading
    // zero count of the magnitude, limited by how far the exponent can drop.
    function automatic exp_t model(input bit c, input bit [23:0] m, input bit s, input bit [7:0] e);
        exp_t r;
        int   e0, p, k, ee;
        bit [23:0] mm;
        bit [7:0]  field;
        r.word = 32'd0; r.ovf = 1'b0; r.unf = 1'b0; r.lat = 1; r.accept_cyc = 0;
        e0 = (e == 0) ? 1 : int'(e);
        if (c) begin
            if (e0 + 1 >= 255) begin
                r.word = {s, 8'hFF, 23'd0};
                r.ovf  = 1'b1;
            end else begin
                r.word = {s, 8'(e0 + 1), m[23:1]};
            end
        end else if (m == 0) begin
            r.word = 32'd0;
        end else if (e == 8'hFF) begin
            r.word = {s, 8'hFF, 23'd0};
        end else begin
            p = 0;
            for (int i = 0; i < 24; i++) if (m[i]) p = i;
            k = 23 - p;
            if (k > e0 - 1) k = e0 - 1;
            mm    = m << k;
            ee    = e0 - k;
            field = mm[23] ? 8'(ee) : 8'd0;
            r.word = {s, field, mm[22:0]};
            r.unf  = (field == 8'd0) && (mm[22:0] != 23'd0);
            r.lat  = k + 1;
        end
        return r;
    endfunction

    // Present one operation and hold it until accepted; optionally predict it.
    task automatic send(input bit c, input bit [23:0] m, input bit s, input bit [7:0] e,
                        input bit predict);
        exp_t r;
        int   n;
        @(negedge clk);
        in_valid = 1'b1; carry_in = c; magnitude_in = m; sign_in = s; exponent_in = e;
        n = 0;
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 64'd0, 64'd1);
        end else if (predict) begin
            r = model(c, m, s, e);
            r.accept_cyc = cyc + 1;
            exp_q.push_back(r);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: compare whatever the DUT presents, then decide out_ready.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            check("in_ready_while_out_valid", 64'(in_ready), 64'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_output", 64'(out_valid), 64'd0);
            end else begin
                check("result_flags", {30'd0, result, overflow, underflow},
                      {30'd0, exp_q[0].word, exp_q[0].ovf, exp_q[0].unf});
                if (first) check("latency", 64'(cyc - exp_q[0].accept_cyc + 1), 64'(exp_q[0].lat));
                first = 1'b0;
            end
        end
        out_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        if (!reset && out_valid && out_ready && exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            first = 1'b1;
        end
    end

    initial begin
        bit        c, s;
        bit [23:0] m;
        bit [7:0]  e;
        int        n;
        reset = 1'b1; in_valid = 1'b0; carry_in = 1'b0; magnitude_in = '0;
        sign_in = 1'b0; exponent_in = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_result", {32'd0, result}, 64'd0);
        check("reset_flags", {62'd0, overflow, underflow}, 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        reset = 1'b0;

        // Directed cases with hand-derived words checked against the model.
        check("model_t1", {32'd0, model(1, 24'h000000, 0, 127).word}, 64'h4000_0000);
        check("model_t2b", {32'd0, model(0, 24'h000001, 1, 127).word}, 64'hB400_0000);
        check("model_t5", {32'd0, model(0, 24'h000100, 0, 3).word}, 64'h0000_0400);
        send(1, 24'h000000, 0, 127, 1);
        send(0, 24'h800000, 0, 127, 1);
        send(0, 24'h000001, 1, 127, 1);
        send(0, 24'h000000, 1, 90, 1);
        send(1, 24'h400000, 1, 254, 1);
        send(0, 24'h000100, 0, 3, 1);
        send(0, 24'h123456, 1, 255, 1);
        send(1, 24'hFFFFFF, 0, 255, 1);
        send(0, 24'h000001, 0, 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
        drain();

        // Hold the result in DONE for five cycles; monitor checks stability.
        hold = 1'b1;
        send(0, 24'h800000, 0, 127, 1);
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("hold_reached_done", 64'(out_valid), 64'd1);
        repeat (5) @(negedge clk);
        check("hold_in_ready", 64'(in_ready), 64'd0);
        check("hold_result", {32'd0, result}, 64'h3F80_0000);
        hold = 1'b0;
        drain();

        // Reset in the middle of a long shift sequence aborts it silently.
        send(0, 24'h000001, 1, 127, 0);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_shift_busy", 64'(in_ready), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        repeat (30) @(negedge clk);
        check("abort_no_output", 64'(out_valid), 64'd0);

        // Randomised operations, biased toward the interesting exponents.
        for (int i = 0; i < 200; i++) begin
            c = ($urandom_range(0, 3) == 0);
            s = $urandom_range(0, 1);
            m = 24'($urandom) >> $urandom_range(0, 23);
            if ($urandom_range(0, 15) == 0) m = 24'd0;
            case ($urandom_range(0, 7))
                0: e = 8'd0;
                1: e = 8'd1;
                2: e = 8'd2;
                3: e = 8'd253;
                4: e = 8'd254;
                5: e = 8'd255;
                default: e = 8'($urandom);
            endcase
            send(c, m, s, e, 1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        drain();
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
